bsg_mesh_edge_arb: RTL and testbench

Wormhole round-robin arbiter that shares one off-tile link among the `num_in_p` edge channels of a stitched mesh side (one channel per row for the W/E sides, one per column for the N/S sides). It sits between the edge outputs of the mesh stitching layer and a single serial off-tile port. It locks the grant for the full length of each packet and drives the link from a one-entry output register.

---
 rtl/bsg_noc_pkg.sv | 25 ++
 rtl/bsg_mesh_edge_rr_grant.sv | 51 +++++
 rtl/bsg_mesh_edge_arb.sv | 124 ++++++++++++
 tb/tb_bsg_mesh_edge_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_noc_pkg
//  Brief    : Shared NoC definitions: mesh-edge header layout, default
//             length-field width and edge-arbiter state encoding.
//  Revision : 1.0
// ============================================================================
package bsg_noc_pkg;

  // Default width of the body-flit count field at the bottom of a header.
  localparam int bsg_mesh_edge_len_width_gp = 4;

  // Header view: body-flit count lives in the least significant bits.
  typedef struct packed {
    logic [bsg_mesh_edge_len_width_gp-1:0] len;
  } bsg_mesh_edge_hdr_s;

  // Edge arbiter: no owner, or grant locked to one channel for a packet.
  typedef enum logic [0:0] {
    e_edge_idle   = 1'b0,
    e_edge_locked = 1'b1
  } bsg_mesh_edge_state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_mesh_edge_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mesh_edge_rr_grant
//  Brief    : Combinational round-robin grant. Picks the first valid request
//             at or after the pointer (increasing index, wrapping) and gives
//             both a one-hot grant and its encoded index.
//  Revision : 1.0
// ============================================================================
module bsg_mesh_edge_rr_grant #(
  parameter int num_in_p    = 4,
  parameter int lg_num_in_p = $clog2(num_in_p)
) (
  input  logic [num_in_p-1:0]    v_i,
  input  logic [lg_num_in_p-1:0] ptr_i,
  output logic [num_in_p-1:0]    grant_o,
  output logic [lg_num_in_p-1:0] idx_o,
  output logic                   v_o
);

  // One extra bit so pointer + offset can exceed num_in_p before wrapping.
  localparam int sum_w_lp = lg_num_in_p + 1;

  logic [sum_w_lp-1:0]    sum;
  logic [lg_num_in_p-1:0] cand;
  logic                   found;

  // Scan candidates starting at the pointer; the first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 0; off < num_in_p; off++) begin
      sum = {1'b0, ptr_i} + sum_w_lp'(off);
      if (sum >= sum_w_lp'(num_in_p)) begin
        sum = sum - sum_w_lp'(num_in_p);
      end
      cand = sum[lg_num_in_p-1:0];
      if (!found && v_i[cand]) begin
        found         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

  assign v_o = found;

endmodule
`default_nettype wire

// File: rtl/bsg_mesh_edge_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mesh_edge_arb
//  Brief    : Wormhole round-robin arbiter sharing one off-tile link among
//             the edge channels of a mesh side. The grant is held for a
//             whole packet; the link is driven from a one-entry register.
//  Revision : 1.0
// ============================================================================
module bsg_mesh_edge_arb
  import bsg_noc_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int num_in_p    = 4,
  parameter int len_width_p = bsg_mesh_edge_len_width_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_i
);

  localparam int lg_lp = $clog2(num_in_p);

  bsg_mesh_edge_state_e   state_r, state_n;
  logic [lg_lp-1:0]       owner_r, owner_n;
  logic [lg_lp-1:0]       rr_ptr_r, rr_ptr_n;
  logic [len_width_p-1:0] cnt_r, cnt_n;

  logic [num_in_p-1:0]    gnt_oh;
  logic [lg_lp-1:0]       gnt_idx;
  logic                   gnt_v;
  logic [lg_lp-1:0]       sel;
  logic [width_p-1:0]     sel_data;
  logic [len_width_p-1:0] hdr_len;
  logic                   slot_free;
  logic                   accept;

  bsg_mesh_edge_rr_grant #(
    .num_in_p (num_in_p)
  ) rr_grant (
    .v_i     (v_i),
    .ptr_i   (rr_ptr_r),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .v_o     (gnt_v)
  );

  // The output register can take a flit if it is empty or draining this cycle.
  assign slot_free = ~v_o | ready_i;

  // Select the active channel, drive ready_o and compute the next lock state.
  always_comb begin
    ready_o  = '0;
    sel      = gnt_idx;
    accept   = 1'b0;
    state_n  = state_r;
    owner_n  = owner_r;
    cnt_n    = cnt_r;
    rr_ptr_n = rr_ptr_r;

    if (state_r == e_edge_locked) begin
      sel              = owner_r;
      ready_o[owner_r] = slot_free & ~reset_i;
      accept           = v_i[owner_r] & slot_free & ~reset_i;
    end else begin
      ready_o = gnt_oh & {num_in_p{slot_free & ~reset_i}};
      accept  = gnt_v & slot_free & ~reset_i;
    end

    sel_data = data_i[sel*width_p +: width_p];
    hdr_len  = sel_data[len_width_p-1:0];

    if (accept) begin
      if (state_r == e_edge_idle) begin
        // Pointer moves past the winner on every header, locked or not.
        rr_ptr_n = (sel == lg_lp'(num_in_p - 1)) ? '0 : sel + lg_lp'(1);
        if (hdr_len != '0) begin
          state_n = e_edge_locked;
          owner_n = sel;
          cnt_n   = hdr_len;
        end
      end else begin
        cnt_n = cnt_r - len_width_p'(1);
        if (cnt_r == len_width_p'(1)) begin
          state_n = e_edge_idle;
        end
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_edge_idle;
      owner_r  <= '0;
      cnt_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      cnt_r    <= cnt_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  // One-entry link register: load on accept, otherwise empty when dequeued.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else if (accept) begin
      v_o    <= 1'b1;
      data_o <= sel_data;
    end else if (ready_i) begin
      v_o    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_mesh_edge_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_mesh_edge_arb
//  Brief    : Self-checking bench for bsg_mesh_edge_arb with per-channel
//             packet FIFOs and a packet-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_bsg_mesh_edge_arb;
  import bsg_noc_pkg::*;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int L     = 4;
  localparam int DEPTH = 2048;

  logic           clk;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ready_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_i;

  bsg_mesh_edge_arb #(
    .width_p     (W),
    .num_in_p    (N),
    .len_width_p (L)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream channel FIFOs (flits: [15:12]=channel, header [3:0]=len).
  logic [W-1:0] fifo [N][DEPTH];
  int           head [N];
  int           tail [N];

  // Reference model: packet owner (-1 = none), flits left, pointer, link reg.
  int           m_owner;
  int           m_rem;
  int           m_ptr;
  logic         m_vo;
  logic [W-1:0] m_data;

  int  errors;
  int  checks;
  int  link_log [$];
  int  exp_q [$];
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic flush();
    for (int c = 0; c < N; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
  endtask

  task automatic push_pkt(input int ch, input int len);
    logic [W-1:0] f;
    f = W'($urandom);
    f[15:12] = 4'(ch);
    f[3:0]   = 4'(len);
    if (tail[ch] < DEPTH) begin fifo[ch][tail[ch]] = f; tail[ch]++; end
    for (int b = 0; b < len; b++) begin
      f = W'($urandom);
      f[15:12] = 4'(ch);
      if (tail[ch] < DEPTH) begin fifo[ch][tail[ch]] = f; tail[ch]++; end
    end
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < N; c++) if (tail[c] > head[c]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle. rmode: 0 = link always ready, 1 = random, 2 = stalled.
  task automatic step(input int rmode, input logic rst);
    logic [N-1:0] exp_ready;
    logic         slot_free;
    logic         found;
    int           acc_ch;
    int           c;
    logic [W-1:0] flit;
    bsg_mesh_edge_hdr_s hdr;

    @(negedge clk);
    reset_i = rst;
    ready_i = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    for (int k = 0; k < N; k++) begin
      v_i[k] = (tail[k] > head[k]) && (rmode != 1 || $urandom_range(0, 3) != 0);
      data_i[k*W +: W] = (tail[k] > head[k]) ? fifo[k][head[k]] : '0;
    end
    #1;

    // Expected handshake from the packet-level rules.
    exp_ready = '0;
    acc_ch    = -1;
    slot_free = !m_vo || ready_i;
    if (!rst && slot_free) begin
      if (m_owner >= 0) begin
        exp_ready[m_owner] = 1'b1;
      end else begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (!found && v_i[c]) begin
            exp_ready[c] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) if (exp_ready[k] && v_i[k]) acc_ch = k;

    check("ready_o", 32'(ready_o), 32'(exp_ready));
    check("v_o", 32'(v_o), 32'(m_vo));
    check("data_o", 32'(data_o), 32'(m_data));
    last_ready = ready_o;

    if (!rst && v_o && ready_i) link_log.push_back(int'(data_o[15:12]));
    if (!rst) for (int k = 0; k < N; k++) if (v_i[k] && ready_o[k]) head[k]++;

    // Advance the model to the state after this clock edge.
    if (rst) begin
      m_owner = -1; m_rem = 0; m_ptr = 0; m_vo = 1'b0; m_data = '0;
    end else if (acc_ch >= 0) begin
      flit = data_i[acc_ch*W +: W];
      if (m_owner < 0) begin
        m_ptr = (acc_ch + 1) % N;
        hdr   = flit[L-1:0];
        if (hdr.len != 0) begin
          m_owner = acc_ch;
          m_rem   = int'(hdr.len);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_owner = -1;
      end
      m_vo   = 1'b1;
      m_data = flit;
    end else if (ready_i) begin
      m_vo = 1'b0;
    end
  endtask

  task automatic drain(input int rmode);
    int n;
    n = 0;
    while ((!all_empty() || m_vo) && n < 2000) begin
      step(rmode, 1'b0);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_head(input int ch, input int cnt);
    int n;
    n = 0;
    while (head[ch] < cnt && n < 200) begin
      step(0, 1'b0);
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(link_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < link_log.size(); i++)
      check(tag, 32'(link_log[i]), 32'(exp_q[i]));
  endtask

  initial begin
    errors = 0; checks = 0;
    reset_i = 1'b1; ready_i = 1'b1; v_i = '0; data_i = '0;
    m_owner = -1; m_rem = 0; m_ptr = 0; m_vo = 1'b0; m_data = '0;
    flush();

    // Reset with every channel valid, then round robin of single flits.
    for (int c = 0; c < N; c++) push_pkt(c, 0);
    for (int c = 0; c < N; c++) push_pkt(c, 0);
    step(0, 1'b1);
    step(0, 1'b1);
    link_log.delete();
    step(0, 1'b0);
    check("first_grant", 32'(last_ready), 32'h1);
    drain(0);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("rr_order");

    // Wormhole lock with a mid-packet stall; pointer is first moved to 2.
    flush(); step(0, 1'b1);
    push_pkt(0, 0); push_pkt(1, 0);
    drain(0);
    link_log.delete();
    push_pkt(2, 3); push_pkt(0, 0); push_pkt(1, 0);
    wait_head(2, 2);
    repeat (5) step(2, 1'b0);
    check("bp_no_accept", 32'(head[2]), 32'd2);
    drain(0);
    exp_q = '{2, 2, 2, 2, 0, 1};
    check_log("wormhole");

    // Maximum-length packet followed by a waiting single flit.
    link_log.delete();
    push_pkt(3, 15); push_pkt(0, 0);
    drain(0);
    exp_q = '{};
    for (int i = 0; i < 16; i++) exp_q.push_back(3);
    exp_q.push_back(0);
    check_log("max_len");

    // Reset after 2 of 6 flits; pointer must restart at 0 (ch1 before ch3).
    flush(); step(0, 1'b1);
    push_pkt(2, 5);
    wait_head(2, 2);
    flush(); step(0, 1'b1);
    link_log.delete();
    push_pkt(3, 0); push_pkt(1, 0);
    drain(0);
    exp_q = '{1, 3};
    check_log("mid_reset");

    // Randomized traffic, gaps and backpressure against the model.
    flush(); step(0, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++)
        if (tail[c] - head[c] < 8 && $urandom_range(0, 5) == 0)
          push_pkt(c, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
      step(1, 1'b0);
    end
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
